pass_scheduler: RTL

- Sequences the image-processing passes over the 20x20 pixel register file once loading completes.
- EDGE mode order: median -> gaussian -> sobel -> non-max -> hysteresis. COLOR mode order: gaussian -> median -> quantize.
- For each pass, scans every interior 3x3 window centre, issues window requests to the shared filter datapath under a valid/ready handshake with a credit limit, and counts returned results.
- After the last result of a pass, triggers the temp-to-image write-back. Pulses done after the final pass.

---
 rtl/pass_if.sv | 25 ++
 rtl/pass_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pass_if.sv
// Request / result / write-back signals between the pass scheduler and the
// shared filter datapath.
interface pass_if;
  // Valid/ready: a window request transfers on any rising edge where
  // req_valid & req_ready are both high; while req_valid is high and
  // req_ready is low, win_row/win_col are held stable. res_valid and wb_done
  // are single-cycle pulses with no back-pressure.
  logic       req_valid;
  logic       req_ready;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic       res_valid;
  logic       wb_start;
  logic       wb_done;

  modport master (
    output req_valid, win_row, win_col, wb_start,
    input  req_ready, res_valid, wb_done
  );

  modport slave (
    input  req_valid, win_row, win_col, wb_start,
    output req_ready, res_valid, wb_done
  );
endinterface

// File: rtl/pass_scheduler.sv
// Sequences the filter passes over the image: scans every interior 3x3 window
// centre per pass under a credit limit, then triggers temp-to-image write-back.
module pass_scheduler #(
  parameter int IMG_DIM = 20,
  parameter int MAX_OUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  pass_if.master     bus,
  output logic [2:0] op,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // op encoding: 0 idle, 1 median, 2 gaussian, 3 sobel, 4 nms, 5 hyst, 6 quant
  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_MED   = 3'd1;
  localparam logic [2:0] OP_GAU   = 3'd2;
  localparam logic [2:0] OP_HYST  = 3'd5;
  localparam logic [2:0] OP_QUANT = 3'd6;

  localparam logic [4:0] LAST     = 5'(IMG_DIM - 2);
  localparam logic [8:0] TOTAL    = 9'((IMG_DIM - 2) * (IMG_DIM - 2));
  localparam logic [8:0] LAST_IDX = 9'((IMG_DIM - 2) * (IMG_DIM - 2) - 1);
  localparam logic [2:0] CREDITS  = 3'(MAX_OUT);

  state_t     state, state_d;
  logic       mode_q;
  logic [2:0] op_q;
  logic [4:0] row, col;
  logic [8:0] issued, returned;
  logic [2:0] outst;
  logic       wb_sent;
  logic       err_q;

  logic accept, last_accept, res_dec, res_count, err_set, last_op;

  function automatic logic [2:0] next_op(input logic m, input logic [2:0] cur);
    logic [2:0] n;
    if (cur == OP_IDLE)  n = m ? OP_GAU : OP_MED;
    else if (!m)         n = cur + 3'd1;
    else if (cur == OP_GAU) n = OP_MED;
    else                 n = OP_QUANT;
    return n;
  endfunction

  assign bus.req_valid = (state == S_SCAN) && (outst < CREDITS);
  assign bus.win_row   = row;
  assign bus.win_col   = col;
  assign bus.wb_start  = (state == S_WB) && !wb_sent;

  assign accept      = bus.req_valid && bus.req_ready;
  assign last_accept = accept && (issued == LAST_IDX);
  // Results still in flight after an abort drain the credit count in IDLE
  // without being counted or flagged.
  assign res_dec     = bus.res_valid && (outst != 3'd0);
  assign res_count   = res_dec && ((state == S_SCAN) || (state == S_DRAIN));
  assign err_set     = bus.res_valid &&
                       ((outst == 3'd0) || (state == S_SETUP) ||
                        (state == S_WB) || (state == S_FIN));
  assign last_op     = mode_q ? (op_q == OP_QUANT) : (op_q == OP_HYST);

  assign op        = op_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN);
  assign err       = err_q;
  assign dbg_state = state;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: state_d = S_SCAN;
      S_SCAN:  if (last_accept) state_d = S_DRAIN;
      S_DRAIN: if (returned == TOTAL) state_d = S_WB;
      S_WB:    if (bus.wb_done) state_d = last_op ? S_FIN : S_SETUP;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      op_q     <= OP_IDLE;
      row      <= 5'd1;
      col      <= 5'd1;
      issued   <= 9'd0;
      returned <= 9'd0;
      outst    <= 3'd0;
      wb_sent  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state   <= state_d;
      wb_sent <= (state == S_WB);
      if (err_set) err_q <= 1'b1;
      if (accept && !res_dec)      outst <= outst + 3'd1;
      else if (!accept && res_dec) outst <= outst - 3'd1;
      if (res_count) returned <= returned + 9'd1;
      case (state)
        S_IDLE: if (start) mode_q <= mode;
        S_SETUP: begin
          op_q     <= next_op(mode_q, op_q);
          row      <= 5'd1;
          col      <= 5'd1;
          issued   <= 9'd0;
          returned <= 9'd0;
        end
        S_SCAN: begin
          // The final window holds its coordinates until the next SETUP.
          if (accept) begin
            issued <= issued + 9'd1;
            if (!last_accept) begin
              if (col == LAST) begin
                col <= 5'd1;
                row <= row + 5'd1;
              end else begin
                col <= col + 5'd1;
              end
            end
          end
        end
        S_FIN:   op_q <= OP_IDLE;
        default: ;
      endcase
      if (abort && (state != S_IDLE)) op_q <= OP_IDLE;
    end
  end

endmodule
